// File: rtl/pu_pkg.sv
// Shared constants and types for the PU requantize/drain stage.
package pu_pkg;

    localparam int unsigned ACC_WIDTH   = 32;
    localparam int unsigned MAC_NUM     = 8;
    localparam int unsigned OUT_WIDTH   = 8;
    localparam int unsigned SHIFT_WIDTH = 5;

    // Drain sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_t;

    // One lane widened by a bit so the rounding add can never overflow
    typedef logic signed [ACC_WIDTH:0] requant_lane_t;

endpackage : pu_pkg

// File: rtl/pu_requant.sv
// Single-lane requantizer: rounding arithmetic right shift, optional ReLU,
// saturation to a signed OUT_WIDTH result. Purely combinational.
module pu_requant
    import pu_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = pu_pkg::ACC_WIDTH,
    parameter int unsigned OUT_WIDTH   = pu_pkg::OUT_WIDTH,
    parameter int unsigned SHIFT_WIDTH = pu_pkg::SHIFT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]   acc_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    input  logic                          relu_en_i,
    output logic signed [OUT_WIDTH-1:0]   q_o
);

    typedef logic signed [ACC_WIDTH:0] lane_ext_t;

    localparam lane_ext_t SAT_MAX = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam lane_ext_t SAT_MIN = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    lane_ext_t ext;
    lane_ext_t rnd;
    lane_ext_t sum;
    lane_ext_t shr;
    lane_ext_t rel;

    // Round half up, shift, clamp negatives when ReLU is on, then saturate
    always_comb begin
        ext = {acc_i[ACC_WIDTH-1], acc_i};
        rnd = '0;
        if (shift_i != '0) begin
            rnd = lane_ext_t'(1) << (shift_i - 1'b1);
        end
        sum = ext + rnd;
        shr = sum >>> shift_i;
        rel = shr;
        if (relu_en_i && shr[ACC_WIDTH]) begin
            rel = '0;
        end
        if (rel > SAT_MAX) begin
            q_o = SAT_MAX[OUT_WIDTH-1:0];
        end else if (rel < SAT_MIN) begin
            q_o = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            q_o = rel[OUT_WIDTH-1:0];
        end
    end

endmodule : pu_requant

// File: rtl/pu_requant_drain.sv
// Snapshots the PU accumulator vector on capture, requantizes lane by lane
// and streams the results out over a valid/ready interface.
module pu_requant_drain
    import pu_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = pu_pkg::ACC_WIDTH,
    parameter int unsigned MAC_NUM     = pu_pkg::MAC_NUM,
    parameter int unsigned OUT_WIDTH   = pu_pkg::OUT_WIDTH,
    parameter int unsigned SHIFT_WIDTH = pu_pkg::SHIFT_WIDTH,
    localparam int unsigned IDX_W      = $clog2(MAC_NUM)
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           capture_i,
    input  logic [ACC_WIDTH*MAC_NUM-1:0]   matmul_i,
    input  logic [SHIFT_WIDTH-1:0]         shift_i,
    input  logic                           relu_en_i,
    output logic                           ready_o,
    output logic [OUT_WIDTH-1:0]           dout_o,
    output logic [IDX_W-1:0]               dout_idx_o,
    output logic                           dout_valid_o,
    input  logic                           dout_ready_i,
    output logic                           dout_last_o,
    output logic                           overflow_o,
    input  logic                           ovf_clr_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAC_NUM - 1);

    drain_state_t                   state_q;
    logic [ACC_WIDTH*MAC_NUM-1:0]   snap_q;
    logic [SHIFT_WIDTH-1:0]         shift_q;
    logic                           relu_q;
    logic                           ready_q;
    logic                           valid_q;
    logic [OUT_WIDTH-1:0]           dout_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           last_q;
    logic                           ovf_q;

    logic [IDX_W-1:0]               sel_idx;
    logic signed [ACC_WIDTH-1:0]    lane_acc;
    logic signed [OUT_WIDTH-1:0]    dout_d;
    logic                           handshake;

    assign handshake = valid_q & dout_ready_i;

    // Lane select: lane 0 while loading, otherwise the lane after the one on the output
    always_comb begin
        sel_idx  = (state_q == ST_LOAD) ? '0 : idx_q + 1'b1;
        lane_acc = snap_q[ACC_WIDTH*int'(sel_idx) +: ACC_WIDTH];
    end

    pu_requant #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc_i     (lane_acc),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .q_o       (dout_d)
    );

    // Drain sequencer with registered outputs and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            dout_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (capture_i && !ready_q) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (capture_i) begin
                        snap_q  <= matmul_i;
                        shift_q <= shift_i;
                        relu_q  <= relu_en_i;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dout_q  <= dout_d;
                    idx_q   <= '0;
                    last_q  <= (LAST_IDX == '0);
                    valid_q <= 1'b1;
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            dout_q <= dout_d;
                            idx_q  <= idx_q + 1'b1;
                            last_q <= ((idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign dout_o       = dout_q;
    assign dout_idx_o   = idx_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign overflow_o   = ovf_q;

endmodule : pu_requant_drain

// File: tb/tb_pu_requant_drain.sv
// Directed bench for pu_requant_drain with hand-computed expected lanes.
module tb_pu_requant_drain;

    logic         clk = 1'b0;
    logic         rstn;
    logic         capture;
    logic [255:0] matmul;
    logic [4:0]   shift;
    logic         relu_en;
    logic         ready;
    logic signed [7:0] dout;
    logic [2:0]   dout_idx;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         overflow;
    logic         ovf_clr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pu_requant_drain dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .capture_i    (capture),
        .matmul_i     (matmul),
        .shift_i      (shift),
        .relu_en_i    (relu_en),
        .ready_o      (ready),
        .dout_o       (dout),
        .dout_idx_o   (dout_idx),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_last_o  (dout_last),
        .overflow_o   (overflow),
        .ovf_clr_i    (ovf_clr)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one capture pulse; returns at the point after the sampling edge
    task automatic do_capture(input int v[8], input int sh, input bit relu);
        for (int i = 0; i < 8; i++) matmul[i*32 +: 32] = v[i];
        shift   = 5'(sh);
        relu_en = relu;
        capture = 1'b1;
        step();
        capture = 1'b0;
        matmul  = {8{32'h5A5A_A5A5}};
        shift   = 5'd0;
        relu_en = 1'b0;
        chk("ready_fall", int'(ready), 0);
    endtask

    // Consume lanes until stop_at handshakes; checks value/idx/last every valid cycle
    task automatic drain(input int exp[8], input bit rnd, input int stop_at, output int cycles);
        int k;
        bit rdy;
        k = 0;
        cycles = 0;
        while (k < stop_at && cycles < 200) begin
            if (!dout_valid) begin
                chk("valid_hold", int'(dout_valid), 1);
                break;
            end
            chk($sformatf("dout_l%0d", k), int'(dout), exp[k]);
            chk($sformatf("idx_l%0d", k), int'(dout_idx), k);
            chk($sformatf("last_l%0d", k), int'(dout_last), (k == 7) ? 1 : 0);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = rdy;
            step();
            cycles++;
            if (rdy) k++;
        end
        if (k < stop_at) chk("drain_progress", k, stop_at);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_valid"}, int'(dout_valid), 0);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_last"}, int'(dout_last), 0);
    endtask

    int v_seq[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int v_mix[8]  = '{100000, -100000, 383, -385, 127, -128, 200, -1};
    int e_s1[8]   = '{127, -128, 127, -128, 64, -64, 100, 0};
    int e_s2r[8]  = '{127, 0, 96, 0, 32, 0, 50, 0};
    int v_dist[8] = '{5, -6, 7, -8, 9, -10, 11, -12};
    int v_ovf[8]  = '{80, -80, 160, -160, 24, -24, 1000, -1000};
    int e_ovf[8]  = '{10, -10, 20, -20, 3, -3, 125, -125};
    int v_junk[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    int cyc;

    initial begin
        rstn       = 1'b0;
        capture    = 1'b0;
        matmul     = '0;
        shift      = '0;
        relu_en    = 1'b0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        step();
        step();
        chk("rst_ready", int'(ready), 1);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_idx", int'(dout_idx), 0);
        chk("rst_last", int'(dout_last), 0);
        chk("rst_ovf", int'(overflow), 0);
        rstn = 1'b1;
        step();

        // Pass-through, ready tied high: lanes at T+2..T+9, ready back at T+10
        dout_ready = 1'b1;
        do_capture(v_seq, 0, 1'b0);
        chk("load_no_valid", int'(dout_valid), 0);
        step();
        chk("first_valid", int'(dout_valid), 1);
        drain(v_seq, 1'b0, 8, cyc);
        chk("seq_cycles", cyc, 8);
        chk_done("seq_done");

        // Shift 1, no ReLU, saturation both ways (back-to-back capture)
        do_capture(v_mix, 1, 1'b0);
        step();
        drain(e_s1, 1'b0, 8, cyc);
        chk("s1_cycles", cyc, 8);
        chk_done("s1_done");

        // Shift 2 with ReLU
        do_capture(v_mix, 2, 1'b1);
        step();
        drain(e_s2r, 1'b0, 8, cyc);
        chk_done("s2r_done");

        // Random consumer backpressure
        do_capture(v_dist, 0, 1'b0);
        step();
        drain(v_dist, 1'b1, 8, cyc);
        chk_done("rnd_done");

        // Capture while busy: sticky overflow, clear priority, drain unaffected
        dout_ready = 1'b0;
        do_capture(v_ovf, 3, 1'b0);
        chk("ovf_pre", int'(overflow), 0);
        for (int i = 0; i < 8; i++) matmul[i*32 +: 32] = v_junk[i];
        shift   = 5'd0;
        capture = 1'b1;
        step();
        capture = 1'b0;
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_lane0", int'(dout), e_ovf[0]);
        capture = 1'b1;
        ovf_clr = 1'b1;
        step();
        capture = 1'b0;
        chk("ovf_wins_clr", int'(overflow), 1);
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        drain(e_ovf, 1'b0, 8, cyc);
        chk_done("ovf_done");
        chk("ovf_stays_clr", int'(overflow), 0);

        // Reset in the middle of a drain, then a clean capture
        do_capture(v_seq, 0, 1'b0);
        step();
        drain(v_seq, 1'b0, 4, cyc);
        chk("pre_rst_idx", int'(dout_idx), 4);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mrst_valid", int'(dout_valid), 0);
        chk("mrst_ready", int'(ready), 1);
        chk("mrst_idx", int'(dout_idx), 0);
        chk("mrst_dout", int'(dout), 0);
        chk("mrst_last", int'(dout_last), 0);
        step();
        step();
        chk("mrst_quiet", int'(dout_valid), 0);
        do_capture(v_dist, 0, 1'b0);
        step();
        drain(v_dist, 1'b0, 8, cyc);
        chk_done("post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pu_requant_drain
